// File: rtl/pc_redirect_ctrl_pkg.sv
// rtl/pc_redirect_ctrl_pkg.sv - shared encodings for the PC redirect controller
// Purpose: PC-select codes, reset PC, controller state encoding and the
// default exception drain length used by pc_redirect_ctrl and its hold register.
package pc_redirect_ctrl_pkg;

  localparam logic [1:0] PC_SEL_PC_PLUS_4   = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH_JUMP = 2'b01;
  localparam logic [1:0] PC_SEL_JALR        = 2'b10;
  localparam logic [1:0] PC_SEL_EXCEPTION   = 2'b11;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam int DRAIN_CYCLES_DEF = 2;
  localparam int DRAIN_W          = 4;  // holds DRAIN_CYCLES up to 15

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HOLD      = 2'd1,
    ST_EXC_DRAIN = 2'd2,
    ST_EXC_ISSUE = 2'd3
  } state_t;

endpackage

// File: rtl/pc_redirect_ctrl_hold.sv
// rtl/pc_redirect_ctrl_hold.sv - pending redirect kind/target register
// Purpose: remembers a redirect that arrived while fetch was stalled.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   load               capture load_sel/load_target
//   clear              discard the pending redirect (wins over load)
//   load_sel[1:0]      PC-select code of the redirect being captured
//   load_target[31:0]  target of the redirect being captured
//   pend_sel[1:0]      held PC-select code (PC_SEL_PC_PLUS_4 when empty)
//   pend_target[31:0]  held target
module pc_redirect_hold
  import pc_redirect_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [1:0]  load_sel,
  input  logic [31:0] load_target,
  output logic [1:0]  pend_sel,
  output logic [31:0] pend_target
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_sel    <= PC_SEL_PC_PLUS_4;
      pend_target <= '0;
    end else if (clear) begin
      pend_sel    <= PC_SEL_PC_PLUS_4;
      pend_target <= '0;
    end else if (load) begin
      pend_sel    <= load_sel;
      pend_target <= load_target;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - fetch PC redirect sequencing controller
// Purpose: merges branch/JAL, JALR and exception redirects with fetch and
// hazard stalls; drives the PC-select code, targets, IF stall and flushes.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   stall_req_i, imem_wait_i        external stall sources
//   br_jump_req_i/br_jump_target_i  taken branch or JAL from EX
//   jalr_req_i/jalr_target_i        JALR from EX
//   exc_req_i                       exception request pulse
//   pc_sel_o                        PC mux select
//   branch_jump_target_addr_o       branch/JAL target (0 when not selected)
//   jalr_target_addr_o              JALR target (0 when not selected)
//   stall_if_o, flush_if_o, flush_id_o  pipeline control
//   busy_o                          controller not in RUN
//   proto_err_o                     sticky: branch and JALR seen together
//   redirect_cnt_o                  saturating count of issued redirects
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_req_i,
  input  logic             imem_wait_i,
  input  logic             br_jump_req_i,
  input  logic [31:0]      br_jump_target_i,
  input  logic             jalr_req_i,
  input  logic [31:0]      jalr_target_i,
  input  logic             exc_req_i,
  output logic [1:0]       pc_sel_o,
  output logic [31:0]      branch_jump_target_addr_o,
  output logic [31:0]      jalr_target_addr_o,
  output logic             stall_if_o,
  output logic             flush_if_o,
  output logic             flush_id_o,
  output logic             busy_o,
  output logic             proto_err_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  state_t             state, state_nxt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               ext_stall;
  logic [1:0]         req_sel;
  logic [31:0]        req_target;
  logic [1:0]         pend_sel;
  logic [31:0]        pend_target;
  logic [31:0]        sel_target;
  logic               hold_load, hold_clear, drain_load;

  assign ext_stall = stall_req_i | imem_wait_i;

  // Branch/JAL has priority over JALR when both are presented.
  assign req_sel    = br_jump_req_i ? PC_SEL_BRANCH_JUMP :
                      jalr_req_i    ? PC_SEL_JALR        : PC_SEL_PC_PLUS_4;
  assign req_target = br_jump_req_i ? br_jump_target_i : jalr_target_i;

  pc_redirect_hold u_hold (
    .clk         (clk),
    .rst         (rst),
    .load        (hold_load),
    .clear       (hold_clear),
    .load_sel    (req_sel),
    .load_target (req_target),
    .pend_sel    (pend_sel),
    .pend_target (pend_target)
  );

  // exc_req_i only steers next state and the hold/drain registers, never the
  // same-cycle select or flush outputs, so pc_sel_o has no path from it.
  always_comb begin
    state_nxt  = state;
    pc_sel_o   = PC_SEL_PC_PLUS_4;
    sel_target = '0;
    stall_if_o = ext_stall;
    flush_if_o = 1'b0;
    flush_id_o = 1'b0;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    drain_load = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (req_sel != PC_SEL_PC_PLUS_4 && !ext_stall) begin
          pc_sel_o   = req_sel;
          sel_target = req_target;
          flush_if_o = 1'b1;
          flush_id_o = 1'b1;
        end
        if (exc_req_i) begin
          state_nxt  = ST_EXC_DRAIN;
          drain_load = 1'b1;
        end else if (req_sel != PC_SEL_PC_PLUS_4 && ext_stall) begin
          hold_load = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!ext_stall) begin
          pc_sel_o   = pend_sel;
          sel_target = pend_target;
          flush_if_o = 1'b1;
          flush_id_o = 1'b1;
          hold_clear = 1'b1;
          state_nxt  = ST_RUN;
        end
        if (exc_req_i) begin
          hold_clear = 1'b1;
          drain_load = 1'b1;
          state_nxt  = ST_EXC_DRAIN;
        end
      end
      ST_EXC_DRAIN: begin
        stall_if_o = 1'b1;
        flush_if_o = 1'b1;
        flush_id_o = 1'b1;
        if (drain_cnt <= DRAIN_W'(1)) state_nxt = ST_EXC_ISSUE;
      end
      ST_EXC_ISSUE: begin
        if (!ext_stall) begin
          pc_sel_o   = PC_SEL_EXCEPTION;
          flush_if_o = 1'b1;
          state_nxt  = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  assign branch_jump_target_addr_o = (pc_sel_o == PC_SEL_BRANCH_JUMP) ? sel_target : '0;
  assign jalr_target_addr_o        = (pc_sel_o == PC_SEL_JALR)        ? sel_target : '0;
  assign busy_o                    = (state != ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_RUN;
      drain_cnt      <= '0;
      proto_err_o    <= 1'b0;
      redirect_cnt_o <= '0;
    end else begin
      state <= state_nxt;
      if (drain_load)
        drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
      else if (state == ST_EXC_DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - DRAIN_W'(1);
      if (state == ST_RUN && br_jump_req_i && jalr_req_i)
        proto_err_o <= 1'b1;
      // Any non-sequential select is an issued redirect.
      if (pc_sel_o != PC_SEL_PC_PLUS_4 && redirect_cnt_o != '1)
        redirect_cnt_o <= redirect_cnt_o + CNT_W'(1);
    end
  end

endmodule
